alu_issue_arbiter: RTL

Issue controller that shares the single registered ALU between two requesters: the decode port (0) and the writeback/branch port (1). Each cycle it arbitrates the requests round-robin and drives the ALU operand and opcode inputs. It tracks each operation through the ALU's registered stage and returns the result and zero flag, tagged with the requester ID, on one shared response channel. A credit-limited response FIFO guarantees that no in-flight result is lost while the consumer stalls.

---
 rtl/alu_issue_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
//
// Shares one registered ALU between two requesters: the decode port (id 0) and
// the writeback/branch port (id 1). Each cycle a round-robin arbiter picks at
// most one request and loads it into the registered ALU input stage. A
// two-stage shadow pipeline tracks every issued operation through the ALU's
// own register so that its result can be captured and tagged with the
// requester id. Captured results wait in a small response FIFO. Issue is
// credit-limited: FIFO occupancy plus operations still in the ALU never exceeds
// DEPTH, so a stalled consumer can never cause a result to be dropped.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req0_* / req1_*            requester handshake (valid/ready) and payload
//                              (op, a, b); ready is combinational and at most
//                              one is high in any cycle
//   alu_operation              registered opcode to the ALU, 0 (NOP) when idle
//   alu_primary/alu_secondary  registered operands to the ALU
//   alu_result, alu_zero       registered result and zero flag from the ALU
//   rsp_valid/rsp_ready        response handshake, valid while FIFO non-empty
//   rsp_id/rsp_result/rsp_zero head-of-FIFO response, 0 while empty
// -----------------------------------------------------------------------------
module alu_issue_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [OPW-1:0]   alu_operation,
  output logic [WIDTH-1:0] alu_primary,
  output logic [WIDTH-1:0] alu_secondary,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  // Count register must hold the value DEPTH itself, pointers only 0..DEPTH-1.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DepthLimit = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LastIdx    = PW'(DEPTH - 1);

  typedef enum logic {
    PREFER_REQ0 = 1'b0,
    PREFER_REQ1 = 1'b1
  } rr_e;

  rr_e              rrPtr_q, rrPtr_d;

  logic [OPW-1:0]   aluOp_q, aluOp_d;
  logic [WIDTH-1:0] aluA_q, aluA_d;
  logic [WIDTH-1:0] aluB_q, aluB_d;

  logic             s1Valid_q, s1Valid_d;
  logic             s1Id_q, s1Id_d;
  logic             s2Valid_q;
  logic             s2Id_q;

  logic [CW-1:0]    fifoCount_q, fifoCount_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;

  logic             memId     [DEPTH];
  logic [WIDTH-1:0] memResult [DEPTH];
  logic             memZero   [DEPTH];

  logic [1:0]       inflight;
  logic [CW:0]      creditUsed;
  logic             canIssue;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             fifoNonEmpty;
  logic             push;
  logic             pop;

  // Credit: every accepted operation owns one FIFO slot from issue until it
  // is popped, whether it is still inside the ALU or already buffered.
  always_comb begin
    inflight   = {1'b0, s1Valid_q} + {1'b0, s2Valid_q};
    creditUsed = {1'b0, fifoCount_q} + (CW + 1)'(inflight);
    canIssue   = creditUsed < DepthLimit;
  end

  // Round-robin grant. Only registered state and the valids feed the readys,
  // so a consumer stall cannot combinationally reach the requesters. Readys are
  // held low during reset so nothing is accepted while state is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && canIssue) begin
      if (req0_valid && req1_valid) begin
        if (rrPtr_q == PREFER_REQ0) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    accept = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue stage: load the winner, otherwise present a NOP while the operands
  // keep their last value so the ALU inputs do not toggle needlessly.
  always_comb begin
    rrPtr_d   = rrPtr_q;
    aluOp_d   = '0;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    s1Valid_d = accept;
    s1Id_d    = grant1;
    if (grant0) begin
      rrPtr_d = PREFER_REQ1;
      aluOp_d = req0_op;
      aluA_d  = req0_a;
      aluB_d  = req0_b;
    end else if (grant1) begin
      rrPtr_d = PREFER_REQ0;
      aluOp_d = req1_op;
      aluA_d  = req1_a;
      aluB_d  = req1_b;
    end
  end

  // FIFO bookkeeping. The shadow stage s2 lines up with the cycle in which the
  // ALU register holds that operation's result, so s2 valid means push now.
  always_comb begin
    fifoNonEmpty = fifoCount_q != '0;
    push         = s2Valid_q;
    pop          = fifoNonEmpty && rsp_ready;

    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == LastIdx) ? '0 : wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == LastIdx) ? '0 : rdPtr_q + PW'(1);
    end

    fifoCount_d = fifoCount_q;
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + CW'(1);
      2'b01:   fifoCount_d = fifoCount_q - CW'(1);
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  // Control state. Reset discards everything in flight and buffered and makes
  // requester 0 the preferred winner of the next contended cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q     <= PREFER_REQ0;
      aluOp_q     <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      s1Valid_q   <= 1'b0;
      s1Id_q      <= 1'b0;
      s2Valid_q   <= 1'b0;
      s2Id_q      <= 1'b0;
      fifoCount_q <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      aluOp_q     <= aluOp_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      s1Valid_q   <= s1Valid_d;
      s1Id_q      <= s1Id_d;
      s2Valid_q   <= s1Valid_q;
      s2Id_q      <= s1Id_q;
      fifoCount_q <= fifoCount_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
    end
  end

  // Response storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      memId[wrPtr_q]     <= s2Id_q;
      memResult[wrPtr_q] <= alu_result;
      memZero[wrPtr_q]   <= alu_zero;
    end
  end

  assign alu_operation = aluOp_q;
  assign alu_primary   = aluA_q;
  assign alu_secondary = aluB_q;

  // Head fields are forced to zero while empty so stale entries never show.
  assign rsp_valid  = fifoNonEmpty;
  assign rsp_id     = fifoNonEmpty ? memId[rdPtr_q] : 1'b0;
  assign rsp_result = fifoNonEmpty ? memResult[rdPtr_q] : '0;
  assign rsp_zero   = fifoNonEmpty ? memZero[rdPtr_q] : 1'b0;

endmodule
